bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the binary input width in bits.
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the number of BCD output digits; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH - 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled on the rising edge of clk.
REQ-006 The block SHALL have port bin, input, WIDTH bits: unsigned binary value, captured in the cycle start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse when bcd holds a new result.
REQ-009 The block SHALL have port bcd, output, 4*DIGITS bits: packed BCD result, digit 0 (units) in bits [3:0], registered.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, SHIFT and DONE, using shift-add-3 (double dabble) conversion.
REQ-011 In IDLE or DONE, start=1 SHALL capture bin into a shift register, clear the BCD working register, zero a bit counter and enter SHIFT.
REQ-012 In IDLE with start=0 the FSM SHALL remain in IDLE.
REQ-013 In DONE with start=0 the FSM SHALL go to IDLE.
REQ-014 In each SHIFT cycle, every working digit >= 5 SHALL first have 3 added; the working register and the binary shift register SHALL then shift left one bit as a single combined register, with the binary MSB entering the working register's bit 0.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, then go to DONE.
REQ-016 The transition into DONE SHALL load the final working register into bcd, and done SHALL be 1 for exactly the DONE cycle.
REQ-017 Latency SHALL be WIDTH+1 cycles from the edge that accepts start to the first edge at which done=1 is sampled.
REQ-018 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-019 start SHALL be ignored while in SHIFT; the in-flight conversion and the captured bin SHALL be unaffected.
REQ-020 Changes on bin SHALL be ignored outside the accepting cycle.
REQ-021 bcd SHALL hold its last value until the next transition into DONE.
REQ-022 start held high continuously SHALL produce back-to-back conversions with no IDLE cycle, one result every WIDTH+1 cycles.
REQ-023 Each output digit SHALL be in the range 0-9, except where the blanking value 4'hF of REQ-029 applies.
REQ-024 An input of 0 SHALL yield all-zero digits, and an input of 2^WIDTH-1 SHALL yield its exact decimal value.

Reset
REQ-025 When rst_n=0 the block SHALL, asynchronously, put the FSM in IDLE, set busy=0 and done=0, and clear the working, shift and counter registers.
REQ-026 When rst_n=0 the block SHALL set bcd to the value of REQ-029 if BIN2BCD_BLANK_EN is defined, and to all zeros otherwise.
REQ-027 Reset asserted mid-SHIFT SHALL abort the conversion, and no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising edge of clk.

Configuration
REQ-029 With macro BIN2BCD_BLANK_EN defined, every digit above the most significant nonzero digit SHALL be forced to 4'hF when loaded into bcd; digit 0 SHALL never be blanked, so a value of 0 shows as 4'hF..F0; the all-zero reset value SHALL therefore read 4'hF..F0. (4'hF is the code a downstream seven-segment decoder renders as all segments off.)
REQ-030 With BIN2BCD_BLANK_EN undefined, bcd SHALL carry plain BCD including leading zeros, and no blanking logic SHALL be synthesised.
REQ-031 The macro SHALL NOT alter timing, latency or handshake behaviour.

Verification
REQ-032 The bench SHALL drive bin=8'd255 with a one-cycle start and check: busy high for 8 cycles, done pulse on cycle 9, bcd=12'h255.
REQ-033 The bench SHALL drive bin=8'd0, then bin=8'd100, and check bcd=12'h000 then 12'h100 (12'hFF0 and 12'h100 with BIN2BCD_BLANK_EN).
REQ-034 The bench SHALL drive bin=8'd7 with BIN2BCD_BLANK_EN defined and check bcd=12'hFF7; without the macro bcd=12'h007.
REQ-035 The bench SHALL start bin=8'd42, pulse start with bin=8'd99 on SHIFT cycle 3, and check a single done with bcd=12'h042.
REQ-036 The bench SHALL assert rst_n=0 on SHIFT cycle 4 of bin=8'd200 and check: busy=0, done=0 and bcd at its reset value immediately, and no done pulse afterwards.
REQ-037 The bench SHALL hold start=1 with bin stepping 8'd1, 8'd2, 8'd3 and check done every 9 cycles with bcd 12'h001, 12'h002, 12'h003.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per cycle.
// Define BIN2BCD_BLANK_EN to blank leading zero digits of bcd to 4'hF.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

`ifdef BIN2BCD_BLANK_EN
  localparam logic [BcdW-1:0] AllF   = '1;
  localparam logic [BcdW-1:0] BcdRst = AllF ^ BcdW'(4'hF);

  // Every digit above the most significant nonzero one reads 4'hF; digit 0 is never blanked.
  function automatic logic [BcdW-1:0] fmt(input logic [BcdW-1:0] v);
    logic            lead;
    logic [BcdW-1:0] r;
    r    = v;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (v[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction
`else
  localparam logic [BcdW-1:0] BcdRst = '0;

  function automatic logic [BcdW-1:0] fmt(input logic [BcdW-1:0] v);
    return v;
  endfunction
`endif

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BcdW-1:0]   work_q, work_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BcdW-1:0]   work_adj;
  logic [BcdW+WIDTH-1:0] combined;

  always_comb begin
    work_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      work_adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                      : work_q[4*i +: 4];
    end
  end

  // Working digits and binary shift register move as one register; binary MSB feeds bit 0.
  assign combined = {work_adj, shift_q} << 1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          shift_d = bin;
          work_d  = '0;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        work_d  = combined[BcdW+WIDTH-1:WIDTH];
        shift_d = combined[WIDTH-1:0];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          bcd_d   = fmt(combined[BcdW+WIDTH-1:WIDTH]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= BcdRst;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: scoreboard of expected results, checked on each done pulse.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

`ifdef BIN2BCD_BLANK_EN
  localparam logic [11:0] RstBcd = 12'hFF0;
`else
  localparam logic [11:0] RstBcd = 12'h000;
`endif

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, then optional leading-zero blanking.
  function automatic logic [11:0] model(input int v);
    logic [11:0] r;
    logic        lead;
    int          p;
    p = 1;
    for (int d = 0; d < 3; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
`ifdef BIN2BCD_BLANK_EN
    lead = 1'b1;
    for (int d = 2; d > 0; d--) begin
      if (r[4*d +: 4] != 4'd0) lead = 1'b0;
      if (lead) r[4*d +: 4] = 4'hF;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start at the current negedge; returns just after the accepting edge.
  task automatic start_conv(input logic [7:0] v);
    start = 1'b1;
    bin   = v;
    exp_q.push_back(model(int'(v)));
    @(negedge clk);
    start = 1'b0;
    bin   = ~v;
  endtask

  // Waits (bounded) for done, checks cycles taken and pops/compares the expected result.
  task automatic wait_done(input string tag, input int exp_cycles);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, exp_cycles);
    if (done) begin
      if (exp_q.size() > 0) check({tag, "_bcd"}, {20'd0, bcd}, {20'd0, exp_q.pop_front()});
      else check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end
  endtask

  task automatic count_done(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = 8'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_bcd", {20'd0, bcd}, {20'd0, RstBcd});

    // 255: start on the first edge after reset release, busy for 8 cycles, done on the 9th.
    @(negedge clk);
    rst_n = 1'b1;
    start_conv(8'd255);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("c255_busy%0d", i), {31'd0, busy}, 1);
      check($sformatf("c255_nodone%0d", i), {31'd0, done}, 0);
      if (i < 8) @(negedge clk);
    end
    wait_done("c255", 1);
    check("c255_busy_in_done", {31'd0, busy}, 0);
    check("c255_bcd_lit", {20'd0, bcd}, {20'd0, model(255)});
    @(negedge clk);
    check("c255_done_single", {31'd0, done}, 0);

    start_conv(8'd0);
    wait_done("c0", 8);
    @(negedge clk);
    start_conv(8'd100);
    wait_done("c100", 8);
    @(negedge clk);
    start_conv(8'd7);
    wait_done("c7", 8);
    @(negedge clk);
    // bcd holds between conversions.
    repeat (3) @(negedge clk);
    check("hold_bcd", {20'd0, bcd}, {20'd0, model(7)});

    // start ignored mid-SHIFT.
    start_conv(8'd42);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd99;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'd0;
    wait_done("c42", 5);
    count_done("c42_no_second", 12);
    check("c42_idle_busy", {31'd0, busy}, 0);

    // Reset on SHIFT cycle 4 aborts with no done.
    start_conv(8'd200);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_bcd", {20'd0, bcd}, {20'd0, RstBcd});
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    count_done("abort_no_done", 15);

    // Back-to-back with start held: one result every 9 cycles.
    start = 1'b1;
    bin   = 8'd1;
    exp_q.push_back(model(1));
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      wait_done($sformatf("b2b%0d", k), 8);
      if (k < 3) begin
        bin = 8'(k + 1);
        exp_q.push_back(model(k + 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_end_done", {31'd0, done}, 0);
    check("b2b_end_busy", {31'd0, busy}, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
